// File: rtl/ads131_pkg.sv
// ads131_pkg: shared types and constants for the ADS131A0x power-up/run sequencer
// and its command/NULL transfer helper.
package ads131_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_RST_LOW  = 4'd1,
      S_POR_WAIT = 4'd2,
      S_POLL     = 4'd3,
      S_POLL_CHK = 4'd4,
      S_POLL_GAP = 4'd5,
      S_UNLOCK   = 4'd6,
      S_CFG      = 4'd7,
      S_READBACK = 4'd8,
      S_WAKEUP   = 4'd9,
      S_RUN      = 4'd10,
      S_ERROR    = 4'd11
   } state_t;

   typedef enum logic [2:0] {
      X_IDLE      = 3'd0,
      X_CMD_REQ   = 3'd1,
      X_CMD_WAIT  = 3'd2,
      X_NULL_REQ  = 3'd3,
      X_NULL_WAIT = 3'd4
   } xfer_state_t;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_READY    = 3'd1;
   localparam logic [2:0] ERR_UNLOCK   = 3'd2;
   localparam logic [2:0] ERR_WREG     = 3'd3;
   localparam logic [2:0] ERR_WAKEUP   = 3'd4;
   localparam logic [2:0] ERR_READBACK = 3'd5;

   localparam logic [15:0] CMD_NULL   = 16'h0000;
   localparam logic [15:0] CMD_UNLOCK = 16'h0655;
   localparam logic [15:0] CMD_WAKEUP = 16'h0033;
   localparam logic [15:0] OP_WREG    = 16'h4000;
   localparam logic [15:0] OP_RREG    = 16'h2000;
   localparam logic [15:0] ECHO_WREG  = 16'h2000;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ads131_cmd_xfer.sv
// ads131_cmd_xfer: sends one command frame then a NULL frame, and checks the
// pipelined reply carried in the NULL frame's first word against exp_word under cmp_mask.
module ads131_cmd_xfer
   import ads131_pkg::*;
(
   input  logic        system_clock,
   input  logic        reset,
   input  logic        go,
   input  logic [15:0] cmd,
   input  logic [15:0] exp_word,
   input  logic [15:0] cmp_mask,
   input  logic        spi_busy,
   input  logic        spi_done,
   input  logic [15:0] spi_rx_word0,
   output logic        spi_start,
   output logic [15:0] spi_tx_cmd,
   output logic        cmd_done,
   output logic        done,
   output logic        match
);

   xfer_state_t state_q, state_d;
   logic        start_d;
   logic        cmd_done_d;
   logic        done_d;
   logic        match_d;
   logic [15:0] tx_d;

   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         state_q    <= X_IDLE;
         spi_start  <= 1'b0;
         spi_tx_cmd <= CMD_NULL;
         cmd_done   <= 1'b0;
         done       <= 1'b0;
         match      <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         spi_start  <= start_d;
         spi_tx_cmd <= tx_d;
         cmd_done   <= cmd_done_d;
         done       <= done_d;
         match      <= match_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path infers a latch.
      state_d    = state_q;
      start_d    = 1'b0;
      tx_d       = spi_tx_cmd;
      cmd_done_d = 1'b0;
      done_d     = 1'b0;
      match_d    = match;
      case (state_q)
         X_IDLE: begin
            if (go) begin
               tx_d    = cmd;
               state_d = X_CMD_REQ;
            end
         end
         X_CMD_REQ: begin
            if (!spi_busy) begin
               start_d = 1'b1;
               state_d = X_CMD_WAIT;
            end
         end
         X_CMD_WAIT: begin
            // The command word stays on the bus until its frame has finished.
            if (spi_done) begin
               cmd_done_d = 1'b1;
               tx_d       = CMD_NULL;
               state_d    = X_NULL_REQ;
            end
         end
         X_NULL_REQ: begin
            if (!spi_busy) begin
               start_d = 1'b1;
               state_d = X_NULL_WAIT;
            end
         end
         X_NULL_WAIT: begin
            if (spi_done) begin
               done_d  = 1'b1;
               match_d = (((spi_rx_word0 ^ exp_word) & cmp_mask) == 16'h0000);
               state_d = X_IDLE;
            end
         end
         default: state_d = X_IDLE;
      endcase
   end

endmodule

// File: rtl/ads131_seq_ctrl.sv
// ads131_seq_ctrl: ADS131A0x reset, READY polling, unlock/WREG/wakeup sequencing and DRDY
// servicing. Optional register readback after each WREG is enabled by ADS_CFG_READBACK_EN.
module ads131_seq_ctrl
   import ads131_pkg::*;
#(
   parameter int unsigned RST_LOW_CYC  = 1000,
   parameter int unsigned POR_WAIT_CYC = 250000,
   parameter int unsigned POLL_GAP_CYC = 5000,
   parameter int unsigned READY_TRIES  = 16,
   parameter int unsigned NUM_CFG      = 4,
   parameter logic [15:0] READY_WORD   = 16'hFF04
) (
   input  logic                   system_clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [16*NUM_CFG-1:0]  cfg_table,
   input  logic                   drdy_n,
   input  logic                   spi_busy,
   input  logic                   spi_done,
   input  logic [15:0]            spi_rx_word0,
   output logic                   SPI_RESET,
   output logic                   spi_start,
   output logic [15:0]            spi_tx_cmd,
   output logic                   init_done,
   output logic                   sample_strobe,
   output logic                   overrun,
   output logic                   error,
   output logic [2:0]             err_code,
   output logic [3:0]             state_dbg
);

   localparam int unsigned MAX_CYC = max3(RST_LOW_CYC, POR_WAIT_CYC, POLL_GAP_CYC);
   localparam int CNT_W = $clog2(MAX_CYC + 1);
   localparam int IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
   localparam int TRY_W = $clog2(READY_TRIES + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TRY_W-1:0]   tries_q, tries_d;
   logic [2:0]         err_q, err_d;
   logic               spi_reset_q, spi_reset_d;
   logic               go_q, go_d;
   logic               start_ok;
   logic               cfg_last;

   logic [NUM_CFG-1:0][15:0] cfg_arr;
   logic [15:0]        cfg_entry;
   logic [15:0]        xfer_cmd, xfer_exp, xfer_mask;
   logic               xfer_start, xfer_cmd_done, xfer_done, xfer_match;
   logic [15:0]        xfer_tx;

   logic               drdy_m, drdy_s, drdy_p, drdy_fall;
   logic               run_busy, run_pend, run_start;
   logic               run_done, in_flight, launch_req, launch;

   assign cfg_arr   = cfg_table;
   assign cfg_entry = cfg_arr[idx_q];
   assign cfg_last  = (idx_q == IDX_W'(NUM_CFG - 1));

   always_comb begin
      xfer_cmd  = CMD_NULL;
      xfer_exp  = READY_WORD;
      xfer_mask = 16'hFFFF;
      case (state_q)
         S_UNLOCK: begin
            xfer_cmd = CMD_UNLOCK;
            xfer_exp = CMD_UNLOCK;
         end
         S_CFG: begin
            xfer_cmd = OP_WREG | cfg_entry;
            xfer_exp = ECHO_WREG | cfg_entry;
         end
`ifdef ADS_CFG_READBACK_EN
         S_READBACK: begin
            xfer_cmd  = OP_RREG | {cfg_entry[15:8], 8'h00};
            xfer_exp  = {8'h00, cfg_entry[7:0]};
            xfer_mask = 16'h00FF;
         end
`endif
         S_WAKEUP: begin
            xfer_cmd = CMD_WAKEUP;
            xfer_exp = CMD_WAKEUP;
         end
         default: ;
      endcase
   end

   ads131_cmd_xfer u_xfer (
      .system_clock (system_clock),
      .reset        (reset),
      .go           (go_q),
      .cmd          (xfer_cmd),
      .exp_word     (xfer_exp),
      .cmp_mask     (xfer_mask),
      .spi_busy     (spi_busy),
      .spi_done     (spi_done),
      .spi_rx_word0 (spi_rx_word0),
      .spi_start    (xfer_start),
      .spi_tx_cmd   (xfer_tx),
      .cmd_done     (xfer_cmd_done),
      .done         (xfer_done),
      .match        (xfer_match)
   );

   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         tries_q     <= '0;
         err_q       <= ERR_NONE;
         spi_reset_q <= 1'b0;
         go_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         tries_q     <= tries_d;
         err_q       <= err_d;
         spi_reset_q <= spi_reset_d;
         go_q        <= go_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      tries_d     = tries_q;
      err_d       = err_q;
      spi_reset_d = spi_reset_q;
      go_d        = 1'b0;
      start_ok    = 1'b0;
      case (state_q)
         S_IDLE, S_ERROR: begin
            if (start) begin
               start_ok    = 1'b1;
               state_d     = S_RST_LOW;
               cnt_d       = '0;
               tries_d     = '0;
               err_d       = ERR_NONE;
               spi_reset_d = 1'b0;
            end
         end
         S_RST_LOW: begin
            if (cnt_q == CNT_W'(RST_LOW_CYC - 1)) begin
               spi_reset_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_POR_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_POR_WAIT: begin
            if (cnt_q == CNT_W'(POR_WAIT_CYC - 1)) begin
               state_d = S_POLL;
               go_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_POLL: begin
            if (xfer_cmd_done) state_d = S_POLL_CHK;
         end
         S_POLL_CHK: begin
            if (xfer_done) begin
               if (xfer_match) begin
                  state_d = S_UNLOCK;
                  go_d    = 1'b1;
               end else if (tries_q == TRY_W'(READY_TRIES - 1)) begin
                  state_d = S_ERROR;
                  err_d   = ERR_READY;
               end else begin
                  tries_d = tries_q + TRY_W'(1);
                  cnt_d   = '0;
                  state_d = S_POLL_GAP;
               end
            end
         end
         S_POLL_GAP: begin
            if (cnt_q == CNT_W'(POLL_GAP_CYC - 1)) begin
               state_d = S_POLL;
               go_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_UNLOCK: begin
            if (xfer_done) begin
               if (xfer_match) begin
                  idx_d   = '0;
                  state_d = S_CFG;
                  go_d    = 1'b1;
               end else begin
                  state_d = S_ERROR;
                  err_d   = ERR_UNLOCK;
               end
            end
         end
         S_CFG: begin
            if (xfer_done) begin
               if (!xfer_match) begin
                  state_d = S_ERROR;
                  err_d   = ERR_WREG;
               end else begin
                  go_d = 1'b1;
`ifdef ADS_CFG_READBACK_EN
                  state_d = S_READBACK;
`else
                  if (cfg_last) state_d = S_WAKEUP;
                  else          idx_d   = idx_q + IDX_W'(1);
`endif
               end
            end
         end
`ifdef ADS_CFG_READBACK_EN
         S_READBACK: begin
            if (xfer_done) begin
               if (!xfer_match) begin
                  state_d = S_ERROR;
                  err_d   = ERR_READBACK;
               end else begin
                  go_d = 1'b1;
                  if (cfg_last) begin
                     state_d = S_WAKEUP;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = S_CFG;
                  end
               end
            end
         end
`endif
         S_WAKEUP: begin
            if (xfer_done) begin
               if (xfer_match) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_ERROR;
                  err_d   = ERR_WAKEUP;
               end
            end
         end
         default: ;
      endcase
   end

   // DRDY is asynchronous: two flops to synchronise, a third to find the falling edge.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         drdy_m <= 1'b1;
         drdy_s <= 1'b1;
         drdy_p <= 1'b1;
      end else begin
         drdy_m <= drdy_n;
         drdy_s <= drdy_m;
         drdy_p <= drdy_s;
      end
   end

   assign drdy_fall  = drdy_p & ~drdy_s;
   assign run_done   = run_busy & spi_done;
   assign in_flight  = (run_busy & ~spi_done) | run_pend;
   assign launch_req = run_pend | (drdy_fall & ~in_flight);
   assign launch     = launch_req & ~spi_busy & ~(run_busy & ~spi_done);

   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         run_busy      <= 1'b0;
         run_pend      <= 1'b0;
         run_start     <= 1'b0;
         sample_strobe <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         run_start     <= 1'b0;
         sample_strobe <= 1'b0;
         if (start_ok) overrun <= 1'b0;
         if (state_q == S_RUN) begin
            if (run_done) begin
               sample_strobe <= 1'b1;
               run_busy      <= 1'b0;
            end
            if (drdy_fall && in_flight) overrun <= 1'b1;
            if (launch) begin
               run_start <= 1'b1;
               run_busy  <= 1'b1;
               run_pend  <= 1'b0;
            end else if (launch_req) begin
               run_pend <= 1'b1;
            end
         end
      end
   end

   // The transfer helper always finishes on a NULL word, so RUN frames reuse its command register.
   assign spi_start  = xfer_start | run_start;
   assign spi_tx_cmd = xfer_tx;
   assign SPI_RESET  = spi_reset_q;
   assign init_done  = (state_q == S_RUN);
   assign error      = (state_q == S_ERROR);
   assign err_code   = err_q;
   assign state_dbg  = state_q;

endmodule
